// File: rtl/xor5_serial_feeder.sv
`default_nettype none
// ============================================================================
// Module   : xor5_serial_feeder
// Purpose  : Deserializes a 1-bit stream into 5-bit words and presents each
//            word to the 5-input XOR parity stage over valid/ready, with a
//            sticky drop flag and a saturating delivered-word counter.
//            Optional parity reference outputs: XOR5_FEEDER_PARITY_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module xor5_serial_feeder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic             x,
  output logic             y,
  output logic             z,
  output logic             p,
  output logic             q,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  input  logic             clr_overflow,
`ifdef XOR5_FEEDER_PARITY_CHECK_EN
  output logic             perr,
  output logic [CNT_W-1:0] perr_count,
`endif
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  state_t           r_state;
  logic [3:0]       r_sr;
  logic [2:0]       r_idx;
  logic [4:0]       r_word;
  logic             r_valid;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;

  logic       w_complete;
  logic       w_consume;
  logic       w_load;
  logic       w_drop;
  logic [4:0] w_new_word;

  // Bit 4 lands only in COLLECT without a resync; it completes the word.
  assign w_complete = bit_valid & (r_state == S_COLLECT) & ~frame_start & (r_idx == 3'd4);
  assign w_consume  = r_valid & word_ready;
  assign w_load     = w_complete & (~r_valid | word_ready);
  assign w_drop     = w_complete & r_valid & ~word_ready;
  assign w_new_word = {bit_in, r_sr};

`ifdef XOR5_FEEDER_PARITY_CHECK_EN
  logic             r_perr;
  logic [CNT_W-1:0] r_pcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perr <= 1'b0;
      r_pcnt <= '0;
    end else begin
      if (w_load) begin
        r_perr <= ^w_new_word;
      end
      if (w_consume && r_perr && !(&r_pcnt)) begin
        r_pcnt <= r_pcnt + c_one;
      end
    end
  end

  assign perr       = r_perr;
  assign perr_count = r_pcnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_idx   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (bit_valid) begin
        if (r_state == S_IDLE || frame_start) begin
          r_sr    <= {3'b000, bit_in};
          r_idx   <= 3'd1;
          r_state <= S_COLLECT;
        end else if (r_idx == 3'd4) begin
          r_sr    <= '0;
          r_idx   <= 3'd0;
          r_state <= S_IDLE;
        end else begin
          r_sr[r_idx[1:0]] <= bit_in;
          r_idx            <= r_idx + 3'd1;
        end
      end

      // A load in the same cycle as a consume keeps the register full.
      if (w_load) begin
        r_word  <= w_new_word;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end

      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_overflow) begin
        r_ovf <= 1'b0;
      end

      if (w_consume && !(&r_cnt)) begin
        r_cnt <= r_cnt + c_one;
      end
    end
  end

  assign x          = r_word[0];
  assign y          = r_word[1];
  assign z          = r_word[2];
  assign p          = r_word[3];
  assign q          = r_word[4];
  assign word_valid = r_valid;
  assign overflow   = r_ovf;
  assign word_count = r_cnt;

endmodule
`default_nettype wire

// File: doc/xor5_serial_feeder.md
Name: xor5_serial_feeder

Overview:
- Upstream stage for the 5-input XOR parity block: deserializes a 1-bit serial stream into 5-bit words on outputs x, y, z, p, q.
- Each word is presented to the parity stage through a valid/ready handshake.
- One-word output register; a sticky overflow flag marks any dropped word.
- A saturating counter tracks delivered words.

Parameters:
- CNT_W, 8, width of word_count (and of perr_count when the optional feature is compiled in).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is sampled this cycle.
- frame_start  input  1  qualified by bit_valid: this bit is bit 0 of a new word.
- x, y, z, p, q  output  1 each  held word: bit0→x, bit1→y, bit2→z, bit3→p, bit4→q.
- word_valid  output  1  held word is valid.
- word_ready  input  1  consumer accepts the word this cycle.
- overflow  output  1  sticky: a completed word was dropped.
- clr_overflow  input  1  synchronous clear of overflow.
- word_count  output  CNT_W  words accepted by the consumer; saturates at all-ones.

Behaviour:
- Reset, async and active-high: all outputs 0, shift register 0, bit index 0, state IDLE. Applies mid-word and mid-handshake; partial and held words are discarded.
- States:
  - IDLE: no partial bits. A cycle with bit_valid stores bit 0 and goes to COLLECT with index 1.
  - COLLECT: index 1..4.
- Transitions in COLLECT:
  - bit_valid with frame_start: discard the partial word, store the bit as bit 0, index 1, stay in COLLECT (resync).
  - bit_valid without frame_start: store the bit at the current index.
  - If that bit is bit 4: the word is complete; go to IDLE.
  - No bit_valid: hold state.
- frame_start in IDLE is redundant and accepted. frame_start without bit_valid is ignored.
- Completion, on the edge that samples bit 4:
  - Output register empty (word_valid=0), or being consumed this cycle (word_valid & word_ready): load the word; word_valid=1 on the next cycle. Latency is 1 cycle from the sampling edge to visible outputs.
  - Otherwise (word_valid & ~word_ready): drop the new word, keep the held word unchanged, set overflow=1.
- Handshake:
  - x..q stay stable while word_valid & ~word_ready.
  - On word_valid & word_ready with no simultaneous load: word_valid→0, x..q keep their last value.
  - word_ready while word_valid=0 has no effect.
- word_count increments on each word_valid & word_ready, then saturates at 2^CNT_W-1 (no wrap).
- overflow: set has priority over clr_overflow in the same cycle. Otherwise clr_overflow clears it on the next edge.
- Full throughput: one word every 5 bit_valid cycles with word_ready held high. No stalls, no overflow.

Optional Feature:
- Macro: XOR5_FEEDER_PARITY_CHECK_EN.
- With the macro defined:
  - Extra output perr  1 bit: registered alongside the word; equals x^y^z^p^q of the held word. This is a local reference value for the downstream parity stage.
  - Extra output perr_count  CNT_W bits: saturating count of accepted words (valid & ready) with odd parity. Reset value 0.
- Without the macro: neither port exists and no parity logic is generated. All other behaviour is identical.

Test Plan:
- Reset mid-word: feed bits 1,0,1 and assert rst. Then feed 1,1,0,1,0 with word_ready=1 → one word x=1,y=1,z=0,p=1,q=0; word_valid high for exactly 1 cycle; word_count=1.
- Backpressure and overflow: word_ready=0, feed 10 valid bits 1,0,0,0,0,0,1,1,1,1 → x..q hold 1,0,0,0,0; overflow=1 after the 10th bit. Then word_ready=1 → word_count=1. Then clr_overflow → overflow=0.
- Simultaneous consume and load: held word 0,0,0,0,1; word_ready=1 on the same cycle the next word 1,1,1,1,1 completes → word_valid stays 1, outputs 1,1,1,1,1, overflow=0, word_count increments by 1.
- Resync: feed 1,1,1 then frame_start with bits 0,1,0,1,1 → word x=0,y=1,z=0,p=1,q=1; the partial 1,1,1 is discarded.
- Saturation: CNT_W=3, 9 words accepted → word_count=7.
- Feature on, with word_ready=1: words 1,1,0,0,0 then 1,1,1,0,0 → perr 0 then 1; perr_count=1.
